npu_dma_arbiter: RTL and testbench

- Shares the single NPU DMA request port (dma_req_* / dma_resp_done) between NUM_REQ internal requesters, e.g. CQ DMA_COPY decode and the GEMM operand prefetcher.
- Grants round-robin, one transfer outstanding at a time. The grant is locked until the downstream engine signals completion.
- Latches the request payload, routes the completion pulse back to the owner, and flags a watchdog timeout.
- Sits between the descriptor decoders and the AXI DMA shim inside npu_top.

---
 rtl/npu_dma_arb_pkg.sv | 27 ++
 rtl/npu_dma_arbiter_pick.sv | 37 +++
 rtl/npu_dma_arbiter.sv | 140 ++++++++++++++
 tb/tb_npu_dma_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_dma_arb_pkg.sv
// npu_dma_arb_pkg
//   Shared types and constants for the NPU DMA request arbiter:
//   arbiter state encoding, latched DMA payload record, address/length
//   widths and the round-robin pointer advance helper.
package npu_dma_arb_pkg;

    localparam int ADDR_W = 64;
    localparam int LEN_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  bytes;
    } dma_payload_t;

    // Next round-robin start position after owner 'cur' among 'n' requesters.
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/npu_dma_arbiter_pick.sv
// npu_rr_pick
//   Combinational rotate-priority picker. Scans req starting at ptr and
//   wrapping modulo NUM_REQ; the first set bit wins.
//   Ports:
//     req     in  NUM_REQ  request vector
//     ptr     in  IDX_W    highest-priority index for this scan
//     onehot  out NUM_REQ  one-hot winner (0 when nothing requests)
//     idx     out IDX_W    winner index (0 when nothing requests)
//     any     out 1        at least one request present
module npu_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int unsigned j;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            j = (32'(ptr) + off) % NUM_REQ;
            if (!any && req[j]) begin
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/npu_dma_arbiter.sv
// npu_dma_arbiter
//   Shares the single NPU DMA request port between NUM_REQ requesters.
//   Round-robin grant, one transfer outstanding; the grant is held until the
//   downstream engine reports completion. Zero-length requests complete
//   locally without touching the engine. A watchdog flags transfers that
//   stay in flight for TIMEOUT_CYCLES (0 disables it).
//   Ports:
//     clk, rst                      clock, async active-high reset
//     req_valid/src/dst/bytes       per-requester request, packed by index
//     req_ready                     one-hot accept (combinational, IDLE only)
//     req_done                      one-hot completion pulse (registered)
//     dma_req_valid/src/dst/bytes   downstream request with latched payload
//     dma_req_ready, dma_resp_done  downstream accept / completion pulse
//     busy                          transfer in progress
//     grant_id                      current or last owner
//     err_timeout, err_spurious     sticky error flags
module npu_dma_arbiter
    import npu_dma_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ID_W           = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_src,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dst,
    input  logic [NUM_REQ*LEN_W-1:0]  req_bytes,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      dma_req_valid,
    output logic [ADDR_W-1:0]         dma_req_src,
    output logic [ADDR_W-1:0]         dma_req_dst,
    output logic [LEN_W-1:0]          dma_req_bytes,
    input  logic                      dma_req_ready,
    input  logic                      dma_resp_done,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      err_timeout,
    output logic                      err_spurious
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    arb_state_t          state;
    dma_payload_t        pay;
    dma_payload_t        acc_pay;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [WD_W-1:0]     wd_cnt;
    logic [WD_W-1:0]     wd_inc;
    logic                complete;

    npu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        int unsigned sel;
        sel           = 32'(pick_idx);
        acc_pay.src   = req_src[sel*ADDR_W +: ADDR_W];
        acc_pay.dst   = req_dst[sel*ADDR_W +: ADDR_W];
        acc_pay.bytes = req_bytes[sel*LEN_W +: LEN_W];
    end

    // Gated by rst so the combinational accept is also 0 while in reset.
    assign req_ready = (state == IDLE && !rst) ? pick_onehot : '0;

    // Engine may accept and finish in the same ISSUE cycle.
    assign complete = (state == ISSUE && dma_req_ready && dma_resp_done) ||
                      (state == WAIT_DONE && dma_resp_done);

    assign wd_inc        = wd_cnt + 1'b1;
    assign dma_req_valid = (state == ISSUE);
    assign busy          = (state != IDLE);
    assign dma_req_src   = pay.src;
    assign dma_req_dst   = pay.dst;
    assign dma_req_bytes = pay.bytes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pay          <= '0;
            grant_id     <= '0;
            rr_ptr       <= '0;
            req_done     <= '0;
            wd_cnt       <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (dma_resp_done) begin
                        err_spurious <= 1'b1;
                    end
                    if (pick_any) begin
                        pay      <= acc_pay;
                        grant_id <= pick_idx;
                        wd_cnt   <= '0;
                        if (acc_pay.bytes == '0) begin
                            req_done <= pick_onehot;
                            rr_ptr   <= ID_W'(rr_next(32'(pick_idx), NUM_REQ));
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE, WAIT_DONE: begin
                    if (wd_cnt != WD_MAX) begin
                        wd_cnt <= wd_inc;
                        if (TIMEOUT_CYCLES != 0 && wd_inc == WD_MAX) begin
                            err_timeout <= 1'b1;
                        end
                    end
                    if (complete) begin
                        req_done[grant_id] <= 1'b1;
                        rr_ptr             <= ID_W'(rr_next(32'(grant_id), NUM_REQ));
                        state              <= IDLE;
                    end else if (state == ISSUE && dma_req_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_dma_arbiter.sv
// tb_npu_dma_arbiter
//   Self-checking bench for npu_dma_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=16).
//   A transaction-level reference model predicts every output each cycle;
//   directed sequences cover the main scenarios, then randomized traffic.
module tb_npu_dma_arbiter;

    localparam int N    = 2;
    localparam int ID_W = 3;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*64-1:0]   req_src;
    logic [N*64-1:0]   req_dst;
    logic [N*32-1:0]   req_bytes;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_done;
    logic              dma_req_valid;
    logic [63:0]       dma_req_src;
    logic [63:0]       dma_req_dst;
    logic [31:0]       dma_req_bytes;
    logic              dma_req_ready;
    logic              dma_resp_done;
    logic              busy;
    logic [ID_W-1:0]   grant_id;
    logic              err_timeout;
    logic              err_spurious;

    always #5 clk = ~clk;

    npu_dma_arbiter #(
        .NUM_REQ        (N),
        .ID_W           (ID_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_src       (req_src),
        .req_dst       (req_dst),
        .req_bytes     (req_bytes),
        .req_ready     (req_ready),
        .req_done      (req_done),
        .dma_req_valid (dma_req_valid),
        .dma_req_src   (dma_req_src),
        .dma_req_dst   (dma_req_dst),
        .dma_req_bytes (dma_req_bytes),
        .dma_req_ready (dma_req_ready),
        .dma_resp_done (dma_resp_done),
        .busy          (busy),
        .grant_id      (grant_id),
        .err_timeout   (err_timeout),
        .err_spurious  (err_spurious)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_owner;     // requester holding the port, -1 when free
    bit          m_took;      // engine has accepted the current request
    int          m_ptr;       // requester with top priority
    int          m_gid;
    int          m_done_idx;  // requester expected to see req_done now, -1 none
    int          m_wd;
    bit          m_err_to;
    bit          m_err_sp;
    logic [63:0] m_src;
    logic [63:0] m_dst;
    logic [31:0] m_bytes;
    int          m_acc;       // requester accepted at the last edge, -1 none
    int          obs_q[$];    // grant_id observed after each accept

    function automatic int rr_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_took = 0; m_ptr = 0; m_gid = 0; m_done_idx = -1;
        m_wd = 0; m_err_to = 0; m_err_sp = 0;
        m_src = '0; m_dst = '0; m_bytes = '0; m_acc = -1;
    endtask

    task automatic model_step();
        int w;
        bit fin;
        m_acc      = -1;
        m_done_idx = -1;
        if (m_owner < 0) begin
            if (dma_resp_done) m_err_sp = 1;
            w = rr_winner(req_valid, m_ptr);
            if (w >= 0) begin
                m_acc   = w;
                m_gid   = w;
                m_src   = req_src[w*64 +: 64];
                m_dst   = req_dst[w*64 +: 64];
                m_bytes = req_bytes[w*32 +: 32];
                m_wd    = 0;
                if (m_bytes == 0) begin
                    m_done_idx = w;
                    m_ptr      = (w + 1) % N;
                end else begin
                    m_owner = w;
                    m_took  = 0;
                end
            end
        end else begin
            if (m_wd < TO) begin
                m_wd++;
                if (m_wd == TO) m_err_to = 1;
            end
            fin = 0;
            if (!m_took) begin
                if (dma_req_ready) begin
                    if (dma_resp_done) fin = 1;
                    else m_took = 1;
                end
            end else if (dma_resp_done) begin
                fin = 1;
            end
            if (fin) begin
                m_done_idx = m_owner;
                m_ptr      = (m_owner + 1) % N;
                m_owner    = -1;
            end
        end
    endtask

    // Compare all outputs at the falling edge, then advance one clock.
    task automatic tick();
        int w;
        logic [N-1:0] er;
        logic [N-1:0] ed;
        @(negedge clk);
        w  = rr_winner(req_valid, m_ptr);
        er = '0;
        if (m_owner < 0 && w >= 0) er[w] = 1'b1;
        ed = '0;
        if (m_done_idx >= 0) ed[m_done_idx] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("req_done", 64'(req_done), 64'(ed));
        chk("dma_req_valid", 64'(dma_req_valid), 64'(m_owner >= 0 && !m_took));
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("dma_req_src", dma_req_src, m_src);
        chk("dma_req_dst", dma_req_dst, m_dst);
        chk("dma_req_bytes", 64'(dma_req_bytes), 64'(m_bytes));
        chk("err_timeout", 64'(err_timeout), 64'(m_err_to));
        chk("err_spurious", 64'(err_spurious), 64'(m_err_sp));
        @(posedge clk);
        model_step();
        #1;
        if (m_acc >= 0) obs_q.push_back(int'(grant_id));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_done"}, 64'(req_done), 64'd0);
        chk({tag, "_dvalid"}, 64'(dma_req_valid), 64'd0);
        chk({tag, "_src"}, dma_req_src, 64'd0);
        chk({tag, "_dst"}, dma_req_dst, 64'd0);
        chk({tag, "_bytes"}, 64'(dma_req_bytes), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_gid"}, 64'(grant_id), 64'd0);
        chk({tag, "_eto"}, 64'(err_timeout), 64'd0);
        chk({tag, "_esp"}, 64'(err_spurious), 64'd0);
    endtask

    task automatic set_req(input int i, input logic [63:0] s, input logic [63:0] d,
                           input logic [31:0] b);
        req_valid[i]          = 1'b1;
        req_src[i*64 +: 64]   = s;
        req_dst[i*64 +: 64]   = d;
        req_bytes[i*32 +: 32] = b;
    endtask

    task automatic rand_req(input int i);
        logic [31:0] b;
        b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
        set_req(i, {$urandom(), $urandom()}, {$urandom(), $urandom()}, b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_src = '0; req_dst = '0; req_bytes = '0;
        dma_req_ready = 1'b0; dma_resp_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_random(input int n);
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < N; i++) begin
                if (m_acc == i) begin
                    if ($urandom_range(0, 1) == 1) rand_req(i);
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) rand_req(i);
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            dma_req_ready = ($urandom_range(0, 2) == 0);
            dma_resp_done = (m_owner >= 0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        req_valid = '0; dma_req_ready = 1'b0; dma_resp_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        model_reset();
        do_reset();

        // Single transfer by requester 0 with a two-cycle gap before done.
        set_req(0, 64'h30_0000_0000, 64'h30_0010_0000, 32'h100);
        tick();
        req_valid = '0;
        tick();
        dma_req_ready = 1'b1; tick();
        dma_req_ready = 1'b0; tick(); tick();
        dma_resp_done = 1'b1; tick();
        dma_resp_done = 1'b0; tick(); tick();

        // Zero-length by requester 1: completes locally.
        set_req(1, 64'h1111, 64'h2222, 32'd0);
        tick();
        req_valid = '0;
        tick(); tick();

        // Watchdog: engine stalls 20 cycles, then completes normally.
        do_reset();
        set_req(0, 64'hA000, 64'hB000, 32'h40);
        tick();
        req_valid = '0;
        repeat (20) tick();
        chk("timeout_flag", 64'(err_timeout), 64'd1);
        dma_req_ready = 1'b1; tick();
        dma_req_ready = 1'b0; dma_resp_done = 1'b1; tick();
        dma_resp_done = 1'b0; tick(); tick();
        chk("timeout_busy_clear", 64'(busy), 64'd0);

        // Spurious completion while idle.
        dma_resp_done = 1'b1; tick();
        dma_resp_done = 1'b0; tick(); tick();
        chk("spurious_flag", 64'(err_spurious), 64'd1);

        // Fairness with same-cycle accept+done from the engine.
        do_reset();
        obs_q.delete();
        rand_req(0); req_bytes[31:0]  = 32'h80;
        rand_req(1); req_bytes[63:32] = 32'h80;
        for (int t = 0; t < 60 && obs_q.size() < 4; t++) begin
            dma_req_ready = (m_owner >= 0);
            dma_resp_done = (m_owner >= 0);
            tick();
            if (m_acc >= 0) set_req(m_acc, {$urandom(), $urandom()}, 64'h5000, 32'h80);
        end
        req_valid = '0; dma_req_ready = 1'b0; dma_resp_done = 1'b0;
        tick(); tick();
        chk("fair_count", 64'(obs_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("fair_order", 64'((k < obs_q.size()) ? obs_q[k] : 99), 64'(exp_order[k]));
        end

        // After requester 0 is served, requester 1 goes first.
        do_reset();
        set_req(0, 64'h10, 64'h20, 32'd0);
        tick();
        req_valid = '0; tick();
        obs_q.delete();
        set_req(0, 64'h30, 64'h40, 32'd0);
        set_req(1, 64'h50, 64'h60, 32'd0);
        tick();
        chk("rr_after_0", 64'((obs_q.size() > 0) ? obs_q[0] : 99), 64'd1);
        req_valid = '0; tick(); tick();

        // Asynchronous reset in WAIT_DONE, with requests pending.
        set_req(0, 64'h7700, 64'h8800, 32'h20);
        tick();
        req_valid = '0;
        dma_req_ready = 1'b1; tick();
        dma_req_ready = 1'b0; tick();
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 64'h1, 64'h2, 32'h3);
        set_req(1, 64'h4, 64'h5, 32'h6);
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        model_reset();
        req_valid = 2'b01;
        rst = 1'b0;
        obs_q.delete();
        tick();
        chk("rst_regrant", 64'((obs_q.size() > 0) ? obs_q[0] : 99), 64'd0);
        req_valid = '0;
        dma_req_ready = 1'b1; dma_resp_done = 1'b1; tick();
        dma_req_ready = 1'b0; dma_resp_done = 1'b0; tick(); tick();

        // Randomized traffic.
        do_reset();
        run_random(3000);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
